// File: rtl/vmicro16_cluster_cache_apb_if.sv
// APB bus bundle shared by the cluster-side slave port and the SoC-side master port of the
// cluster data cache.
interface vmicro16_cluster_cache_apb_if #(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/vmicro16_cluster_cache_apb.sv
// Direct-mapped, write-through, read-allocate data cache between the cluster APB interconnect
// (slave side) and the SoC main interconnect (master side).
// Caching is enabled by defining VMICRO16_CLUSTER_CACHE_EN; without it the block is a
// registered APB bridge where every transfer takes the miss path.
module vmicro16_cluster_cache_apb #(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CACHE_WORDS = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  vmicro16_cluster_cache_apb_if.slave        s_apb,
  vmicro16_cluster_cache_apb_if.master       m_apb
);

  typedef enum logic [2:0] {StIdle, StLookup, StMSetup, StMAccess, StResp} state_e;

  state_e                state_q;
  logic [BUS_WIDTH-1:0]  addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_q;

  logic                  m_psel_q;
  logic                  m_penable_q;
  logic                  m_pwrite_q;
  logic [BUS_WIDTH-1:0]  m_paddr_q;
  logic [DATA_WIDTH-1:0] m_pwdata_q;

  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  s_setup;
  logic                  s_pready;
  logic [DATA_WIDTH-1:0] s_prdata;

  assign s_setup = s_apb.psel && !s_apb.penable;

`ifdef VMICRO16_CLUSTER_CACHE_EN
  localparam int unsigned INDEX_BITS = $clog2(CACHE_WORDS);
  localparam int unsigned TAG_BITS   = BUS_WIDTH - INDEX_BITS;

  logic [CACHE_WORDS-1:0] valid_q;
  logic [TAG_BITS-1:0]    tag_mem  [CACHE_WORDS];
  logic [DATA_WIDTH-1:0]  data_mem [CACHE_WORDS];
  logic [TAG_BITS-1:0]    rd_tag_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic                   hit_q;
  logic [INDEX_BITS-1:0]  s_idx;
  logic [INDEX_BITS-1:0]  idx_q;
  logic                   m_done;

  assign s_idx  = s_apb.paddr[INDEX_BITS-1:0];
  assign idx_q  = addr_q[INDEX_BITS-1:0];
  assign m_done = (state_q == StMAccess) && m_apb.pready;

  assign hit      = valid_q[idx_q] && (rd_tag_q == addr_q[BUS_WIDTH-1:INDEX_BITS]);
  assign hit_data = rd_data_q;

  // Tag/data RAM: synchronous read on setup, fill on read completion, update on write hit
  always_ff @(posedge clk) begin
    if (state_q == StIdle && s_setup) begin
      rd_tag_q  <= tag_mem[s_idx];
      rd_data_q <= data_mem[s_idx];
    end
    if (state_q == StLookup) begin
      hit_q <= hit;
    end
    if (m_done && !write_q) begin
      tag_mem[idx_q]  <= addr_q[BUS_WIDTH-1:INDEX_BITS];
      data_mem[idx_q] <= m_apb.prdata;
    end else if (m_done && write_q && hit_q) begin
      data_mem[idx_q] <= wdata_q;
    end
  end

  // Valid bits: the only reset storage; writes never allocate
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (m_done && !write_q) begin
      valid_q[idx_q] <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Transfer FSM with registered master-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      resp_q      <= '0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_setup) begin
            addr_q  <= s_apb.paddr;
            write_q <= s_apb.pwrite;
            wdata_q <= s_apb.pwdata;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit && !write_q) begin
            state_q <= StIdle;
          end else begin
            m_psel_q    <= 1'b1;
            m_penable_q <= 1'b0;
            m_paddr_q   <= addr_q;
            m_pwrite_q  <= write_q;
            m_pwdata_q  <= wdata_q;
            state_q     <= StMSetup;
          end
        end
        StMSetup: begin
          m_penable_q <= 1'b1;
          state_q     <= StMAccess;
        end
        StMAccess: begin
          if (m_apb.pready) begin
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            resp_q      <= write_q ? '0 : m_apb.prdata;
            state_q     <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Slave response: zero-wait read hit in LOOKUP, otherwise one RESP cycle
  always_comb begin
    s_pready = 1'b0;
    s_prdata = '0;
    if (state_q == StLookup && hit && !write_q) begin
      s_pready = 1'b1;
      s_prdata = hit_data;
    end else if (state_q == StResp) begin
      s_pready = 1'b1;
      s_prdata = resp_q;
    end
  end

  assign s_apb.pready   = s_pready;
  assign s_apb.prdata   = s_prdata;
  assign m_apb.psel     = m_psel_q;
  assign m_apb.penable  = m_penable_q;
  assign m_apb.pwrite   = m_pwrite_q;
  assign m_apb.paddr    = m_paddr_q;
  assign m_apb.pwdata   = m_pwdata_q;

endmodule

// File: tb/tb_vmicro16_cluster_cache_apb.sv
// Directed bench for vmicro16_cluster_cache_apb. Expectations follow the build: with
// VMICRO16_CLUSTER_CACHE_EN defined, repeat reads hit; otherwise every transfer is a miss.
module tb_vmicro16_cluster_cache_apb;

`ifdef VMICRO16_CLUSTER_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vmicro16_cluster_cache_apb_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) s_if ();
  vmicro16_cluster_cache_apb_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) m_if ();

  vmicro16_cluster_cache_apb #(
    .BUS_WIDTH  (16),
    .DATA_WIDTH (16),
    .CACHE_WORDS(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s_apb(s_if),
    .m_apb(m_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rdata;
    int          waits;
    int          m_cnt;
    logic [15:0] m_addr;
    logic        m_write;
    logic [15:0] m_wdata;
    int          stab_err;
    int          nz_err;
  } obs_t;

  // Hit expectations depend on the build
  int          ew_hit;
  int          em_hit;

  // One S-side transfer with a cycle-accurate SoC slave model; returns what was observed
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                      input logic [15:0] m_rdata, input int m_wait, output obs_t o);
    int low = 0;
    bit done = 1'b0;
    o = '{rdata: 16'h0, waits: 0, m_cnt: 0, m_addr: 16'h0, m_write: 1'b0, m_wdata: 16'h0,
          stab_err: 0, nz_err: 0};
    @(negedge clk);
    s_if.psel = 1'b1; s_if.penable = 1'b0;
    s_if.paddr = addr; s_if.pwrite = wr; s_if.pwdata = wdata;
    @(posedge clk);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      s_if.penable = 1'b1;
      if (m_if.psel && !m_if.penable) begin
        o.m_cnt++;
        o.m_addr = m_if.paddr; o.m_write = m_if.pwrite; o.m_wdata = m_if.pwdata;
        m_if.pready = 1'b0;
      end else if (m_if.psel && m_if.penable) begin
        if (m_if.paddr !== o.m_addr || m_if.pwrite !== o.m_write || m_if.pwdata !== o.m_wdata)
          o.stab_err++;
        if (low < m_wait) begin
          low++; m_if.pready = 1'b0; m_if.prdata = 16'hFFFF;
        end else begin
          m_if.pready = 1'b1; m_if.prdata = m_rdata;
        end
      end else begin
        m_if.pready = 1'b0;
      end
      if (s_if.pready === 1'b1) begin
        o.rdata = s_if.prdata;
        done = 1'b1;
      end else begin
        o.waits++;
        if (s_if.prdata !== 16'h0) o.nz_err++;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    logic [68:0] outs;
    reset = 1'b1;
    s_if.psel = 1'b0; s_if.penable = 1'b0; s_if.paddr = 16'h0; s_if.pwrite = 1'b0;
    s_if.pwdata = 16'h0; m_if.pready = 1'b0; m_if.prdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {s_if.pready, s_if.prdata, m_if.psel, m_if.penable, m_if.pwrite, m_if.paddr,
            m_if.pwdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_miss_hit();
    obs_t o;
    xfer(16'h0010, 1'b0, 16'h0, 16'hBEEF, 0, o);
    checks++; if (o.rdata !== 16'hBEEF) begin
      errors++; $display("FAIL miss_rdata got=%h exp=%h", o.rdata, 16'hBEEF); end
    checks++; if (o.waits !== 3) begin
      errors++; $display("FAIL miss_waits got=%0d exp=3", o.waits); end
    checks++; if (o.m_cnt !== 1 || o.m_addr !== 16'h0010 || o.m_write !== 1'b0) begin
      errors++; $display("FAIL miss_mbus got cnt=%0d addr=%h wr=%b exp cnt=1 addr=0010 wr=0",
                         o.m_cnt, o.m_addr, o.m_write); end
    checks++; if (o.nz_err !== 0) begin
      errors++; $display("FAIL miss_prdata_idle got=%0d nonzero exp=0", o.nz_err); end
    xfer(16'h0010, 1'b0, 16'h0, 16'h1111, 0, o);
    checks++; if (o.rdata !== (CacheEn ? 16'hBEEF : 16'h1111)) begin
      errors++; $display("FAIL hit_rdata got=%h exp=%h", o.rdata,
                         CacheEn ? 16'hBEEF : 16'h1111); end
    checks++; if (o.waits !== ew_hit || o.m_cnt !== em_hit) begin
      errors++; $display("FAIL hit_timing got waits=%0d mcnt=%0d exp waits=%0d mcnt=%0d",
                         o.waits, o.m_cnt, ew_hit, em_hit); end
  endtask

  task automatic test_write_hit();
    obs_t o;
    xfer(16'h0010, 1'b1, 16'h1234, 16'hDEAD, 0, o);
    checks++; if (o.m_cnt !== 1 || o.m_addr !== 16'h0010 || o.m_write !== 1'b1 ||
                  o.m_wdata !== 16'h1234) begin
      errors++; $display("FAIL wr_mbus got cnt=%0d addr=%h wr=%b data=%h exp 1/0010/1/1234",
                         o.m_cnt, o.m_addr, o.m_write, o.m_wdata); end
    checks++; if (o.rdata !== 16'h0 || o.waits !== 3) begin
      errors++; $display("FAIL wr_resp got data=%h waits=%0d exp data=0000 waits=3",
                         o.rdata, o.waits); end
    xfer(16'h0010, 1'b0, 16'h0, 16'h2222, 0, o);
    checks++; if (o.rdata !== (CacheEn ? 16'h1234 : 16'h2222) || o.m_cnt !== em_hit) begin
      errors++; $display("FAIL wr_readback got data=%h mcnt=%0d exp data=%h mcnt=%0d", o.rdata,
                         o.m_cnt, CacheEn ? 16'h1234 : 16'h2222, em_hit); end
  endtask

  task automatic test_evict();
    obs_t o;
    xfer(16'h0050, 1'b0, 16'h0, 16'hAAAA, 0, o);
    checks++; if (o.rdata !== 16'hAAAA || o.m_addr !== 16'h0050 || o.m_cnt !== 1) begin
      errors++; $display("FAIL evict_fill got data=%h addr=%h cnt=%0d exp AAAA/0050/1",
                         o.rdata, o.m_addr, o.m_cnt); end
    xfer(16'h0010, 1'b0, 16'h0, 16'h3333, 0, o);
    checks++; if (o.rdata !== 16'h3333 || o.m_cnt !== 1 || o.waits !== 3) begin
      errors++; $display("FAIL evict_remiss got data=%h cnt=%0d waits=%0d exp 3333/1/3",
                         o.rdata, o.m_cnt, o.waits); end
  endtask

  task automatic test_write_no_alloc();
    obs_t o;
    xfer(16'h0020, 1'b1, 16'h5555, 16'hDEAD, 0, o);
    checks++; if (o.m_addr !== 16'h0020 || o.m_write !== 1'b1 || o.m_wdata !== 16'h5555 ||
                  o.rdata !== 16'h0) begin
      errors++; $display("FAIL wmiss_mbus got addr=%h wr=%b data=%h resp=%h exp 0020/1/5555/0",
                         o.m_addr, o.m_write, o.m_wdata, o.rdata); end
    xfer(16'h0020, 1'b0, 16'h0, 16'h4444, 0, o);
    checks++; if (o.rdata !== 16'h4444 || o.m_cnt !== 1) begin
      errors++; $display("FAIL wmiss_noalloc got data=%h cnt=%0d exp 4444/1", o.rdata, o.m_cnt);
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    xfer(16'h0077, 1'b0, 16'h0, 16'h5A5A, 5, o);
    checks++; if (o.waits !== 8 || o.rdata !== 16'h5A5A) begin
      errors++; $display("FAIL slow_read got waits=%0d data=%h exp 8/5A5A", o.waits, o.rdata);
    end
    checks++; if (o.stab_err !== 0 || o.nz_err !== 0) begin
      errors++; $display("FAIL slow_read_stable got stab=%0d nz=%0d exp 0/0",
                         o.stab_err, o.nz_err); end
    xfer(16'h0078, 1'b1, 16'hC3C3, 16'hDEAD, 2, o);
    checks++; if (o.waits !== 5 || o.m_wdata !== 16'hC3C3 || o.stab_err !== 0 ||
                  o.rdata !== 16'h0) begin
      errors++; $display("FAIL slow_write got waits=%0d data=%h stab=%0d resp=%h exp 5/C3C3/0/0",
                         o.waits, o.m_wdata, o.stab_err, o.rdata); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit found = 1'b0;
    logic [68:0] outs;
    xfer(16'h0010, 1'b0, 16'h0, 16'h1357, 0, o);
    checks++; if (o.rdata !== (CacheEn ? 16'h3333 : 16'h1357)) begin
      errors++; $display("FAIL pre_reset_read got=%h exp=%h", o.rdata,
                         CacheEn ? 16'h3333 : 16'h1357); end
    // Start a store that will be abandoned in M_ACCESS
    @(negedge clk);
    s_if.psel = 1'b1; s_if.penable = 1'b0; s_if.paddr = 16'h0011;
    s_if.pwrite = 1'b1; s_if.pwdata = 16'h7E7E;
    @(posedge clk);
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      s_if.penable = 1'b1; m_if.pready = 1'b0;
      if (m_if.psel && m_if.penable) found = 1'b1;
      else @(posedge clk);
    end
    checks++; if (!found) begin
      errors++; $display("FAIL reach_maccess got=0 exp=1"); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outs = {s_if.pready, s_if.prdata, m_if.psel, m_if.penable, m_if.pwrite, m_if.paddr,
            m_if.pwdata};
    checks++; if (outs !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    reset = 1'b0; s_if.psel = 1'b0; s_if.penable = 1'b0;
    @(posedge clk);
    xfer(16'h0010, 1'b0, 16'h0, 16'h6666, 0, o);
    checks++; if (o.rdata !== 16'h6666 || o.m_cnt !== 1 || o.waits !== 3) begin
      errors++; $display("FAIL post_reset_miss got data=%h cnt=%0d waits=%0d exp 6666/1/3",
                         o.rdata, o.m_cnt, o.waits); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    xfer(16'h0010, 1'b0, 16'h0, 16'h7777, 0, o);
    checks++; if (o.rdata !== (CacheEn ? 16'h6666 : 16'h7777) || o.waits !== ew_hit) begin
      errors++; $display("FAIL b2b_read got data=%h waits=%0d exp data=%h waits=%0d", o.rdata,
                         o.waits, CacheEn ? 16'h6666 : 16'h7777, ew_hit); end
    xfer(16'h0010, 1'b1, 16'h9999, 16'hDEAD, 0, o);
    checks++; if (o.m_wdata !== 16'h9999 || o.waits !== 3 || o.rdata !== 16'h0) begin
      errors++; $display("FAIL b2b_write got data=%h waits=%0d resp=%h exp 9999/3/0000",
                         o.m_wdata, o.waits, o.rdata); end
    xfer(16'h0010, 1'b0, 16'h0, 16'h2468, 0, o);
    checks++; if (o.rdata !== (CacheEn ? 16'h9999 : 16'h2468) || o.m_cnt !== em_hit) begin
      errors++; $display("FAIL b2b_readback got data=%h cnt=%0d exp data=%h cnt=%0d", o.rdata,
                         o.m_cnt, CacheEn ? 16'h9999 : 16'h2468, em_hit); end
  endtask

  initial begin
    ew_hit = CacheEn ? 0 : 3;
    em_hit = CacheEn ? 0 : 1;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_evict();
    test_write_no_alloc();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    s_if.psel = 1'b0; s_if.penable = 1'b0; m_if.pready = 1'b0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmicro16_cluster_cache_apb.md
Name: vmicro16_cluster_cache_apb

Overview:
Direct-mapped, write-through, read-allocate data cache between the cluster APB interconnect and the SoC main interconnect. It is an APB slave on the cluster IC master port for DMEM traffic, and an APB master toward soc.IC_DMEM. Read hits complete with zero wait states and generate no SoC bus traffic. Misses and all writes are forwarded as single APB transfers.

Parameters:
- BUS_WIDTH, 16, APB address width (word address).
- DATA_WIDTH, 16, APB data width.
- CACHE_WORDS, 64, number of one-word lines; power of 2, at least 2. Localparam INDEX_BITS = log2(CACHE_WORDS). Tag width = BUS_WIDTH - INDEX_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- S_PADDR  in  BUS_WIDTH  slave address from cluster IC.
- S_PWRITE  in  1  1 = write.
- S_PSELx  in  1  slave select.
- S_PENABLE  in  1  access phase.
- S_PWDATA  in  DATA_WIDTH  write data.
- S_PRDATA  out  DATA_WIDTH  read data.
- S_PREADY  out  1  transfer complete.
- M_PADDR  out  BUS_WIDTH  master address to soc IC.
- M_PWRITE  out  1  master write.
- M_PSELx  out  1  master select.
- M_PENABLE  out  1  master access phase.
- M_PWDATA  out  DATA_WIDTH  master write data.
- M_PRDATA  in  DATA_WIDTH  master read data.
- M_PREADY  in  1  master transfer complete.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- Address split: index = S_PADDR[INDEX_BITS-1:0]; tag = S_PADDR[BUS_WIDTH-1:INDEX_BITS]. Aliasing addresses evict each other.
- Storage: valid[CACHE_WORDS], tag array, data array. Only the valid bits are reset (cleared to 0). Tag and data arrays are synchronous-read RAM and are not reset.
- Reset values: S_PREADY=0, S_PRDATA=0, M_PSELx=0, M_PENABLE=0, M_PWRITE=0, M_PADDR=0, M_PWDATA=0. FSM = IDLE.
- FSM states: IDLE, LOOKUP, M_SETUP, M_ACCESS, RESP.
- IDLE:
  - On S_PSELx=1 and S_PENABLE=0 (setup phase), issue an array read at the index and latch address, write flag and write data. Go to LOOKUP.
- LOOKUP (first S access cycle):
  - hit = valid & (tag match).
  - Read hit: S_PREADY=1 and S_PRDATA = array data, combinationally in this cycle. Return to IDLE.
  - Read miss or any write: go to M_SETUP.
- M_SETUP:
  - M_PSELx=1, M_PENABLE=0. M_PADDR and M_PWRITE come from the latched request; M_PWDATA = latched data.
  - Next state is M_ACCESS.
- M_ACCESS:
  - M_PSELx=1, M_PENABLE=1. Hold until M_PREADY=1. M_PADDR, M_PWRITE and M_PWDATA stay stable throughout.
  - On M_PREADY=1:
    - Read: write M_PRDATA to the data array, set the tag, set valid, and capture M_PRDATA into the response register.
    - Write that hits: update the data word in place.
    - Write that misses: no allocation.
  - Deassert M_PSELx/M_PENABLE on the next cycle. Go to RESP.
- RESP:
  - S_PREADY=1 for exactly one cycle. For reads, S_PRDATA = captured data; for writes, S_PRDATA=0. Return to IDLE.
- Latency:
  - Read hit: 0 wait states.
  - Miss or write: 3 + N wait states, where N is the number of M_PREADY-low cycles in M_ACCESS.
- S_PREADY is 0 in all other states. S_PRDATA is 0 whenever S_PREADY=0.
- At most one outstanding transfer. A new setup phase is only accepted in IDLE.
- If S_PSELx drops mid-transfer (protocol violation), the M-side transfer completes and the fill is performed; the response cycle is still produced but ignored upstream.
- Reset mid-operation (any state): next cycle all outputs are at reset values, the FSM is in IDLE and all lines are invalid. The in-flight M transfer is abandoned.

Optional Feature:
- Macro: VMICRO16_CLUSTER_CACHE_EN.
- Defined: caching behaves as described above.
- Undefined: the tag, data and valid arrays are not instantiated and hit is forced to 0. Every transfer, read or write, takes the LOOKUP→M_SETUP→M_ACCESS→RESP path, so the block acts as a registered APB bridge with identical port timing for misses.

Test Plan:
- After reset, read 0x0010 with SoC returning 0xBEEF → one M read at 0x0010 and S_PRDATA=0xBEEF in RESP. A second read of 0x0010 → no M_PSELx activity; S_PREADY=1 in the first access cycle with data 0xBEEF.
- With 0x0010 cached, write 0x1234 to 0x0010 → M write at 0x0010 with data 0x1234. A following read of 0x0010 hits and returns 0x1234 with no M traffic.
- With CACHE_WORDS=64, read 0x0050 (SoC returns 0xAAAA) → evicts index 0x10. A following read of 0x0010 misses and issues an M read.
- Write 0x5555 to uncached 0x0020 → M write occurs with no allocation. A following read of 0x0020 misses and issues an M read.
- Hold M_PREADY low for 5 cycles on a miss → S_PREADY stays 0 and M_PADDR/M_PWDATA stay stable; completion arrives after 8 wait states. Repeat, asserting reset during M_ACCESS → outputs are 0 the next cycle, and a read of the previously cached 0x0010 misses.
- Build without VMICRO16_CLUSTER_CACHE_EN, read 0x0010 twice → two M reads, each with 3 wait states when M_PREADY=1 immediately.
